// File: rtl/pong_pkg.sv
// Shared PONG types and screen geometry for the paddle tracking path.
package pong_pkg;

    localparam int SCREEN_H = 768;
    localparam int PADDLE_H = 128;

    typedef logic [8:0] dist_t;
    typedef logic [9:0] ypos_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLAMP,
        ST_MAP,
        ST_AVG,
        ST_MOVE
    } tracker_state_t;

endpackage

// File: rtl/paddle_slew.sv
// Combinational slew limiter: steps cur toward target by at most MAX_STEP rows.
// Zero latency; no flow control.
module paddle_slew
    import pong_pkg::*;
#(
    parameter int MAX_STEP = 16
) (
    input  ypos_t cur,
    input  ypos_t target,
    output ypos_t next
);

    localparam logic signed [10:0] L_STEP = 11'(MAX_STEP);

    logic signed [10:0] w_diff;

    assign w_diff = $signed({1'b0, target}) - $signed({1'b0, cur});

    always_comb begin
        next = target;
        if (w_diff > L_STEP) begin
            next = cur + ypos_t'(MAX_STEP);
        end else if (w_diff < -L_STEP) begin
            next = cur - ypos_t'(MAX_STEP);
        end
    end

endmodule

// File: rtl/paddle_tracker.sv
// Per-frame distance -> paddle row tracker (clamp, map, optional 4-frame average, slew limit).
// Latency 4 cycles from frame_tick; PADDLE_AVG_EN enables the averaging history; ticks outside IDLE are dropped.
module paddle_tracker
    import pong_pkg::*;
#(
    parameter int DIST_MIN = 10,
    parameter int DIST_MAX = 110,
    parameter int Y_SCALE  = 102,
    parameter int Y_MAX    = SCREEN_H - PADDLE_H,
    parameter int MAX_STEP = 16
) (
    input  logic  clk,
    input  logic  rst,
    input  logic  frame_tick,
    input  dist_t distance,
    output ypos_t paddle_y,
    output logic  paddle_upd
);

    localparam ypos_t L_Y_RESET = ypos_t'(Y_MAX / 2);

    tracker_state_t r_state;
    dist_t          r_d;
    ypos_t          r_t;
    ypos_t          r_avg;
    ypos_t          r_paddle_y;
    logic           r_upd;

    logic [15:0] w_off;
    logic [15:0] w_prod;
    logic [15:0] w_shift;
    ypos_t       w_next;

    assign w_off   = 16'(r_d) - 16'(DIST_MIN);
    assign w_prod  = w_off * 16'(Y_SCALE);
    assign w_shift = w_prod >> 4;

`ifdef PADDLE_AVG_EN
    ypos_t       r_hist [4];
    logic [11:0] w_sum;

    // Sum includes the incoming sample, so the average reflects this frame.
    assign w_sum = 12'(r_t) + 12'(r_hist[0]) + 12'(r_hist[1]) + 12'(r_hist[2]);
`endif

    paddle_slew #(
        .MAX_STEP (MAX_STEP)
    ) u_slew (
        .cur    (r_paddle_y),
        .target (r_avg),
        .next   (w_next)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= ST_IDLE;
            r_d        <= '0;
            r_t        <= '0;
            r_avg      <= '0;
            r_paddle_y <= L_Y_RESET;
            r_upd      <= 1'b0;
`ifdef PADDLE_AVG_EN
            for (int i = 0; i < 4; i++) begin
                r_hist[i] <= L_Y_RESET;
            end
`endif
        end else begin
            r_upd <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (frame_tick && (distance != '0)) begin
                        r_d     <= distance;
                        r_state <= ST_CLAMP;
                    end
                end
                ST_CLAMP: begin
                    if (r_d < dist_t'(DIST_MIN)) begin
                        r_d <= dist_t'(DIST_MIN);
                    end else if (r_d > dist_t'(DIST_MAX)) begin
                        r_d <= dist_t'(DIST_MAX);
                    end
                    r_state <= ST_MAP;
                end
                ST_MAP: begin
                    r_t     <= (w_shift > 16'(Y_MAX)) ? ypos_t'(Y_MAX) : w_shift[9:0];
                    r_state <= ST_AVG;
                end
                ST_AVG: begin
`ifdef PADDLE_AVG_EN
                    r_hist[0] <= r_t;
                    r_hist[1] <= r_hist[0];
                    r_hist[2] <= r_hist[1];
                    r_hist[3] <= r_hist[2];
                    r_avg     <= w_sum[11:2];
`else
                    r_avg     <= r_t;
`endif
                    r_state <= ST_MOVE;
                end
                ST_MOVE: begin
                    r_paddle_y <= w_next;
                    r_upd      <= 1'b1;
                    r_state    <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign paddle_y   = r_paddle_y;
    assign paddle_upd = r_upd;

endmodule
